// File: rtl/aurora_hls_monitor_reader.sv
// Snapshots the link monitor counter bank on request or on a periodic timer.
// Streams the snapshot as one AXI-Stream report: header, counters, XOR checksum.
module aurora_hls_monitor_reader #(
    parameter int          NUM_COUNTERS  = 17,
    parameter int          PERIOD_CYCLES = 0,
    parameter logic [7:0]  REPORT_ID     = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_COUNTERS*32-1:0]   counters_flat,
    input  logic                         snapshot_req,
    output logic                         busy,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [31:0]                  m_tdata,
    output logic                         m_tlast,
    output logic [31:0]                  report_count,
    output logic [31:0]                  dropped_req_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam int         SNAP_W   = NUM_COUNTERS * 32;
    localparam logic [7:0] LAST_IDX = 8'(NUM_COUNTERS - 1);
    localparam logic [7:0] NUM_BYTE = 8'(NUM_COUNTERS);

    function automatic logic [31:0] csum_fold(input logic [31:0] acc, input logic [31:0] word);
        return acc ^ word;
    endfunction

    state_t              state_r,  state_n_s;
    logic                valid_r,  valid_n_s;
    logic                last_r,   last_n_s;
    logic                busy_r,   busy_n_s;
    logic [31:0]         data_r,   data_n_s;
    logic [SNAP_W-1:0]   snap_r,   snap_n_s;
    logic [7:0]          idx_r,    idx_n_s;
    logic [31:0]         csum_r,   csum_n_s;
    logic [15:0]         seq_r,    seq_n_s;
    logic [31:0]         rep_r,    rep_n_s;
    logic [31:0]         drop_r,   drop_n_s;

    logic                timer_expire_s;
    logic                trigger_s;
    logic                handshake_s;
    logic [31:0]         header_s;

    generate
        if (PERIOD_CYCLES != 0) begin : g_timer
            localparam logic [31:0] TIMER_LAST = 32'(PERIOD_CYCLES - 1);
            logic [31:0] timer_r;

            // Free-running period timer, independent of the report state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    timer_r <= 32'd0;
                end else if (timer_r == TIMER_LAST) begin
                    timer_r <= 32'd0;
                end else begin
                    timer_r <= timer_r + 32'd1;
                end
            end

            assign timer_expire_s = (timer_r == TIMER_LAST);
        end else begin : g_no_timer
            assign timer_expire_s = 1'b0;
        end
    endgenerate

    assign trigger_s   = snapshot_req | timer_expire_s;
    assign handshake_s = valid_r & m_tready;
    assign header_s    = {REPORT_ID, seq_r, NUM_BYTE};

    // Next-state and next-output logic; the snapshot drains by shifting one word per beat.
    always_comb begin
        state_n_s = state_r;
        valid_n_s = valid_r;
        last_n_s  = last_r;
        busy_n_s  = busy_r;
        data_n_s  = data_r;
        snap_n_s  = snap_r;
        idx_n_s   = idx_r;
        csum_n_s  = csum_r;
        seq_n_s   = seq_r;
        rep_n_s   = rep_r;
        drop_n_s  = drop_r;

        if (trigger_s && (state_r != ST_IDLE)) begin
            drop_n_s = drop_r + 32'd1;
        end else begin
            drop_n_s = drop_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_n_s = ST_HEADER;
                    snap_n_s  = counters_flat;
                    csum_n_s  = 32'd0;
                    valid_n_s = 1'b1;
                    busy_n_s  = 1'b1;
                    last_n_s  = 1'b0;
                    data_n_s  = header_s;
                    idx_n_s   = 8'd0;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (handshake_s) begin
                    state_n_s = ST_DATA;
                    idx_n_s   = 8'd0;
                    csum_n_s  = csum_fold(csum_r, data_r);
                    data_n_s  = snap_r[31:0];
                    snap_n_s  = snap_r >> 32;
                end else begin
                    state_n_s = ST_HEADER;
                end
            end
            ST_DATA: begin
                if (handshake_s) begin
                    csum_n_s = csum_fold(csum_r, data_r);
                    if (idx_r == LAST_IDX) begin
                        state_n_s = ST_CHECK;
                        data_n_s  = csum_fold(csum_r, data_r);
                        last_n_s  = 1'b1;
                    end else begin
                        idx_n_s  = idx_r + 8'd1;
                        data_n_s = snap_r[31:0];
                        snap_n_s = snap_r >> 32;
                    end
                end else begin
                    state_n_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (handshake_s) begin
                    state_n_s = ST_IDLE;
                    valid_n_s = 1'b0;
                    busy_n_s  = 1'b0;
                    last_n_s  = 1'b0;
                    data_n_s  = 32'd0;
                    rep_n_s   = rep_r + 32'd1;
                    seq_n_s   = seq_r + 16'd1;
                end else begin
                    state_n_s = ST_CHECK;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                valid_n_s = 1'b0;
                busy_n_s  = 1'b0;
                last_n_s  = 1'b0;
                data_n_s  = 32'd0;
            end
        endcase
    end

    // State, output and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= 32'd0;
            snap_r  <= '0;
            idx_r   <= 8'd0;
            csum_r  <= 32'd0;
            seq_r   <= 16'd0;
            rep_r   <= 32'd0;
            drop_r  <= 32'd0;
        end else begin
            state_r <= state_n_s;
            valid_r <= valid_n_s;
            last_r  <= last_n_s;
            busy_r  <= busy_n_s;
            data_r  <= data_n_s;
            snap_r  <= snap_n_s;
            idx_r   <= idx_n_s;
            csum_r  <= csum_n_s;
            seq_r   <= seq_n_s;
            rep_r   <= rep_n_s;
            drop_r  <= drop_n_s;
        end
    end

    assign busy              = busy_r;
    assign m_tvalid          = valid_r;
    assign m_tdata           = data_r;
    assign m_tlast           = last_r;
    assign report_count      = rep_r;
    assign dropped_req_count = drop_r;

endmodule
